// File: rtl/linreg_pkg.sv
// Shared defaults and FSM encoding for the linear-regression statistics datapath.
package linreg_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned N_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/xy_acc_lane.sv
// One statistic lane: sign-extended running sum with clear, add-enable and a
// registered floor-mean (arithmetic shift by N_LOG2) captured on div_en.
module xy_acc_lane #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned N_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic             div_en,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] avg
);

  localparam int unsigned ACC_W = IN_W + N_LOG2;

  logic signed [ACC_W-1:0] acc_q;

  // N_LOG2 guard bits make overflow impossible for 2^N_LOG2 samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (add_en) begin
      acc_q <= acc_q + {{N_LOG2{din[IN_W-1]}}, din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg <= '0;
    end else if (clr) begin
      avg <= '0;
    end else if (div_en) begin
      avg <= OUT_W'(acc_q >>> N_LOG2);
    end
  end

endmodule

// File: rtl/xy_stats_accum.sv
// Batch accumulator producing means of x and y (and, with XY_MOMENTS_EN
// defined, of x*x and x*y) over 2^N_LOG2 accepted samples.
module xy_stats_accum
  import linreg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_LOG2 = N_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                xy_valid_in,
  output logic                xy_ready_out,
  input  logic [DATA_W-1:0]   x_in,
  input  logic [DATA_W-1:0]   y_in,
  output logic                avg_valid_out,
  output logic [DATA_W-1:0]   x_avg,
  output logic [DATA_W-1:0]   y_avg,
  output logic [2*DATA_W-1:0] xx_avg,
  output logic [2*DATA_W-1:0] xy_avg,
  output logic [N_LOG2:0]     sample_cnt
);

  localparam int unsigned CNT_W  = N_LOG2 + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << N_LOG2) - 1);

  state_e state_q;
  state_e state_d;
  logic   accept_c;
  logic   div_en_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake; clr overrides any sample and restarts the batch.
  always_comb begin
    state_d      = state_q;
    xy_ready_out = 1'b0;
    accept_c     = 1'b0;
    div_en_c     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        xy_ready_out = 1'b1;
        accept_c     = xy_valid_in && !clr;
        if (accept_c) begin
          state_d = (sample_cnt == LAST_CNT) ? ST_DIVIDE : ST_ACCUM;
        end
      end
      ST_DIVIDE: begin
        div_en_c = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clr) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
    end else if (accept_c) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // Valid follows the first DONE cycle, one cycle after the means are captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_valid_out <= 1'b0;
    end else begin
      avg_valid_out <= !clr && (state_q == ST_DONE);
    end
  end

  xy_acc_lane #(.IN_W(DATA_W), .OUT_W(DATA_W), .N_LOG2(N_LOG2)) u_lane_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .add_en (accept_c),
    .div_en (div_en_c),
    .din    (x_in),
    .avg    (x_avg)
  );

  xy_acc_lane #(.IN_W(DATA_W), .OUT_W(DATA_W), .N_LOG2(N_LOG2)) u_lane_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .add_en (accept_c),
    .div_en (div_en_c),
    .din    (y_in),
    .avg    (y_avg)
  );

`ifdef XY_MOMENTS_EN
  logic signed [PROD_W-1:0] x_ext_c;
  logic signed [PROD_W-1:0] y_ext_c;
  logic        [PROD_W-1:0] xx_prod_c;
  logic        [PROD_W-1:0] xy_prod_c;

  // Full-width signed operands so the low PROD_W product bits are exact.
  assign x_ext_c   = {{DATA_W{x_in[DATA_W-1]}}, x_in};
  assign y_ext_c   = {{DATA_W{y_in[DATA_W-1]}}, y_in};
  assign xx_prod_c = x_ext_c * x_ext_c;
  assign xy_prod_c = x_ext_c * y_ext_c;

  xy_acc_lane #(.IN_W(PROD_W), .OUT_W(PROD_W), .N_LOG2(N_LOG2)) u_lane_xx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .add_en (accept_c),
    .div_en (div_en_c),
    .din    (xx_prod_c),
    .avg    (xx_avg)
  );

  xy_acc_lane #(.IN_W(PROD_W), .OUT_W(PROD_W), .N_LOG2(N_LOG2)) u_lane_xy (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .add_en (accept_c),
    .div_en (div_en_c),
    .din    (xy_prod_c),
    .avg    (xy_avg)
  );
`else
  assign xx_avg = '0;
  assign xy_avg = '0;
`endif

endmodule

// File: tb/tb_xy_stats_accum.sv
// Self-checking bench for xy_stats_accum (N_LOG2=3) against a batch-level
// reference model; honours XY_MOMENTS_EN when the same define is set.
module tb_xy_stats_accum;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_LOG2 = 3;
  localparam int          N      = 8;
`ifdef XY_MOMENTS_EN
  localparam bit MOMENTS = 1'b1;
`else
  localparam bit MOMENTS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clr;
  logic                xy_valid_in;
  logic                xy_ready_out;
  logic [DATA_W-1:0]   x_in;
  logic [DATA_W-1:0]   y_in;
  logic                avg_valid_out;
  logic [DATA_W-1:0]   x_avg;
  logic [DATA_W-1:0]   y_avg;
  logic [2*DATA_W-1:0] xx_avg;
  logic [2*DATA_W-1:0] xy_avg;
  logic [N_LOG2:0]     sample_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: batch sums, accepted count, edges since batch completion.
  int     m_cnt;
  longint m_sx, m_sy, m_sxx, m_sxy;
  int     m_age;

  xy_stats_accum #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .xy_valid_in   (xy_valid_in),
    .xy_ready_out  (xy_ready_out),
    .x_in          (x_in),
    .y_in          (y_in),
    .avg_valid_out (avg_valid_out),
    .x_avg         (x_avg),
    .y_avg         (y_avg),
    .xx_avg        (xx_avg),
    .xy_avg        (xy_avg),
    .sample_cnt    (sample_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic longint floor_div(input longint s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_sx = 0; m_sy = 0; m_sxx = 0; m_sxy = 0; m_age = -1;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit have_avg;
    have_avg = (m_age >= 1);
    check({tag, ".ready"}, longint'(xy_ready_out), longint'(m_cnt < N));
    check({tag, ".cnt"},   longint'(sample_cnt), longint'(m_cnt));
    check({tag, ".valid"}, longint'(avg_valid_out), longint'(m_age >= 2));
    check({tag, ".x_avg"}, longint'($signed(x_avg)), have_avg ? floor_div(m_sx) : 0);
    check({tag, ".y_avg"}, longint'($signed(y_avg)), have_avg ? floor_div(m_sy) : 0);
    check({tag, ".xx_avg"}, longint'($signed(xx_avg)),
          (have_avg && MOMENTS) ? floor_div(m_sxx) : 0);
    check({tag, ".xy_avg"}, longint'($signed(xy_avg)),
          (have_avg && MOMENTS) ? floor_div(m_sxy) : 0);
  endtask

  // Check outputs, apply one cycle of inputs, then advance the model one edge.
  task automatic step(input bit v, input logic signed [DATA_W-1:0] x,
                      input logic signed [DATA_W-1:0] y, input bit c, input string tag);
    check_all(tag);
    xy_valid_in = v; x_in = x; y_in = y; clr = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else if (v && m_cnt < N) begin
      m_sx  += longint'(x);
      m_sy  += longint'(y);
      m_sxx += longint'(x) * longint'(x);
      m_sxy += longint'(x) * longint'(y);
      m_cnt++;
      if (m_cnt == N) m_age = 0;
    end else if (m_age >= 0 && m_age < 10) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, tag);
  endtask

  // Finish a completed batch: samples offered in DIVIDE/DONE must be ignored.
  task automatic drain_and_clear(input string tag);
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd77, -16'sd77, 1'b0, tag);
    step(1'b0, '0, '0, 1'b1, {tag, ".clr"});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; xy_valid_in = 1'b0; x_in = '0; y_in = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp, y = 2x, valid every cycle.
    for (int i = 1; i <= N; i++) step(1'b1, DATA_W'(i), DATA_W'(2 * i), 1'b0, "ramp");
    drain_and_clear("ramp_done");

    // Floor rounding of a small negative sum, then a constant negative batch.
    step(1'b1, -16'sd1, 16'sd0, 1'b0, "neg1");
    for (int i = 1; i < N; i++) step(1'b1, 16'sd0, 16'sd0, 1'b0, "neg1");
    drain_and_clear("neg1_done");
    for (int i = 0; i < N; i++) step(1'b1, -16'sd5, -16'sd3, 1'b0, "neg5");
    drain_and_clear("neg5_done");

    // Ramp with 3-cycle gaps between samples.
    for (int i = 1; i <= N; i++) begin
      step(1'b1, DATA_W'(i), DATA_W'(2 * i), 1'b0, "gap");
      idle(3, "gap_idle");
    end
    drain_and_clear("gap_done");

    // clr together with the 5th sample drops it, then a fresh batch of 8s.
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 16'sd1, 1'b0, "clr_pre");
    step(1'b1, 16'sd5, 16'sd1, 1'b1, "clr_hit");
    for (int i = 0; i < N; i++) step(1'b1, 16'sd8, 16'sd2, 1'b0, "clr_post");
    drain_and_clear("clr_done");

    // Asynchronous reset mid-batch, then a batch of 3s.
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 16'sd9, 1'b0, "rst_pre");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) step(1'b1, 16'sd3, -16'sd4, 1'b0, "rst_post");
    drain_and_clear("rst_done");

    // Moments ramp: x = 1..8, y = 1 gives xx 204/8 and xy 36/8.
    for (int i = 1; i <= N; i++) step(1'b1, DATA_W'(i), 16'sd1, 1'b0, "mom");
    drain_and_clear("mom_done");

    // Random batches: full-range data, sparse valid, occasional clr.
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 80 && m_age < 3; k++) begin
        step(($urandom % 4) != 0, DATA_W'($urandom), DATA_W'($urandom),
             ($urandom % 60) == 0, "rand");
      end
      step(1'b0, '0, '0, 1'b1, "rand_clr");
    end
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
